// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: processor clock controller for the Nexys4 top level.
// Generates a runtime-selectable divided clock with debounced pause/run and
// single-step buttons, a clock-enable strobe and a retired-cycle counter.
//
// Ports:
//   CLK_undiv    in   100 MHz board clock
//   RESET        in   asynchronous, active-high reset
//   BTN_PAUSE    in   raw pause/run toggle button (asynchronous)
//   BTN_STEP     in   raw single-step button (asynchronous)
//   DIV_SEL      in   half-period = 2^min(DIV_SEL, MAX_DIV_BITS) cycles
//   CLK_OUT      out  divided processor clock, registered
//   CLK_EN       out  1-cycle pulse in the first cycle CLK_OUT reads 1
//   MODE         out  00 RUN, 01 PAUSED, 10 STEP
//   CYCLE_COUNT  out  number of CLK_OUT rising edges, wraps
module clk_step_ctrl #(
   parameter int unsigned MAX_DIV_BITS    = 26,
   parameter int unsigned SEL_W           = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 32,
   parameter bit          START_PAUSED    = 1'b0
) (
   input  logic             CLK_undiv,
   input  logic             RESET,
   input  logic             BTN_PAUSE,
   input  logic             BTN_STEP,
   input  logic [SEL_W-1:0] DIV_SEL,
   output logic             CLK_OUT,
   output logic             CLK_EN,
   output logic [1:0]       MODE,
   output logic [CNT_W-1:0] CYCLE_COUNT
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [MAX_DIV_BITS-1:0] DivOnes = '1;

   typedef enum logic [1:0] {
      StRun    = 2'b00,
      StPaused = 2'b01,
      StStep   = 2'b10
   } mode_e;

   localparam mode_e ResetMode = START_PAUSED ? StPaused : StRun;

   // ---------------------------------------------------------------------
   // Button path: index 0 = pause, index 1 = step
   // ---------------------------------------------------------------------
   logic [1:0]         btn_raw;
   logic [1:0]         sync1_q, sync2_q, level_q, press_q;
   logic [1:0][DW-1:0] deb_cnt_q;
   logic               pause_press, step_press;

   assign btn_raw     = {BTN_STEP, BTN_PAUSE};
   assign pause_press = press_q[0];
   assign step_press  = press_q[1];

   always_ff @(posedge CLK_undiv or posedge RESET) begin
      if (RESET) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         deb_cnt_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            press_q[i] <= 1'b0;
            if (sync2_q[i] == level_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               // Enough consecutive differing samples: accept the new level.
               level_q[i]   <= sync2_q[i];
               deb_cnt_q[i] <= '0;
               press_q[i]   <= sync2_q[i];
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Divider: the half-period exponent is taken live while the counter is 0
   // (first cycle of a phase) and held from then on for the rest of the phase.
   // ---------------------------------------------------------------------
   logic [SEL_W-1:0]        sel_in, sel_q, sel_cur;
   logic [MAX_DIV_BITS-1:0] div_cnt_q, div_cnt_d, h_m1;
   logic                    terminal;

   always_comb begin
      sel_in   = (32'(DIV_SEL) > MAX_DIV_BITS) ? SEL_W'(MAX_DIV_BITS) : DIV_SEL;
      sel_cur  = (div_cnt_q == '0) ? sel_in : sel_q;
      h_m1     = DivOnes >> (32'(MAX_DIV_BITS) - 32'(sel_cur));
      terminal = (div_cnt_q == h_m1);
   end

   // ---------------------------------------------------------------------
   // Mode FSM and clock generation
   // ---------------------------------------------------------------------
   mode_e            mode_q, mode_d;
   logic             clk_q, clk_d, en_q, en_d, pend_q, pend_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge CLK_undiv or posedge RESET) begin
      if (RESET) begin
         mode_q    <= ResetMode;
         clk_q     <= 1'b0;
         en_q      <= 1'b0;
         pend_q    <= 1'b0;
         count_q   <= '0;
         div_cnt_q <= '0;
         sel_q     <= '0;
      end else begin
         mode_q    <= mode_d;
         clk_q     <= clk_d;
         en_q      <= en_d;
         pend_q    <= pend_d;
         count_q   <= count_d;
         div_cnt_q <= div_cnt_d;
         sel_q     <= sel_cur;
      end
   end

   always_comb begin
      mode_d    = mode_q;
      clk_d     = clk_q;
      en_d      = 1'b0;
      pend_d    = pend_q;
      count_d   = count_q;
      div_cnt_d = div_cnt_q;
      unique case (mode_q)
         StRun: begin
            if (pause_press) pend_d = 1'b1;
            if (terminal) begin
               div_cnt_d = '0;
               if (pend_q) begin
                  // Park low at a phase boundary so no runt high pulse escapes.
                  clk_d  = 1'b0;
                  pend_d = 1'b0;
                  mode_d = StPaused;
               end else begin
                  clk_d = ~clk_q;
                  if (!clk_q) begin
                     en_d    = 1'b1;
                     count_d = count_q + 1'b1;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         StPaused: begin
            clk_d     = 1'b0;
            div_cnt_d = '0;
            pend_d    = 1'b0;
            if (pause_press) begin
               mode_d = StRun;
            end else if (step_press) begin
               mode_d  = StStep;
               clk_d   = 1'b1;
               en_d    = 1'b1;
               count_d = count_q + 1'b1;
            end
         end
         StStep: begin
            pend_d = 1'b0;
            if (terminal) begin
               clk_d     = 1'b0;
               div_cnt_d = '0;
               mode_d    = StPaused;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
         default: begin
            mode_d    = StPaused;
            clk_d     = 1'b0;
            div_cnt_d = '0;
         end
      endcase
   end

   assign CLK_OUT     = clk_q;
   assign CLK_EN      = en_q;
   assign MODE        = mode_q;
   assign CYCLE_COUNT = count_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// tb_clk_step_ctrl: directed bench for clk_step_ctrl with short debounce and a
// 4-bit divider range, expected values hand-computed cycle by cycle.
module tb_clk_step_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_p, btn_s;
   logic [4:0]  div_sel;
   logic        clk_out, clk_en;
   logic [1:0]  mode;
   logic [31:0] count;

   int n_total = 0;
   int n_bad   = 0;

   clk_step_ctrl #(
      .MAX_DIV_BITS   (4),
      .SEL_W          (5),
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (32),
      .START_PAUSED   (1'b0)
   ) dut (
      .CLK_undiv  (clk),
      .RESET      (rst),
      .BTN_PAUSE  (btn_p),
      .BTN_STEP   (btn_s),
      .DIV_SEL    (div_sel),
      .CLK_OUT    (clk_out),
      .CLK_EN     (clk_en),
      .MODE       (mode),
      .CYCLE_COUNT(count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Length of the current CLK_OUT level, counted from the present tick.
   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (clk_out === lvl && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic wait_clk(input logic lvl, input int maxc);
      int k = 0;
      while (clk_out !== lvl && k < maxc) begin
         tick();
         k++;
      end
      check_val("wait_clk", 32'(clk_out), 32'(lvl));
   endtask

   task automatic wait_mode(input logic [1:0] m, input int maxc);
      int k = 0;
      while (mode !== m && k < maxc) begin
         tick();
         k++;
      end
      check_val("wait_mode", 32'(mode), 32'(m));
   endtask

   initial begin
      int n, presses, hi, ens, steps;
      rst = 1'b1; btn_p = 1'b0; btn_s = 1'b0; div_sel = 5'd0;
      tick(); tick();
      check_val("rst_clk", 32'(clk_out), 0);
      check_val("rst_en", 32'(clk_en), 0);
      check_val("rst_count", int'(count), 0);
      check_val("rst_mode", 32'(mode), 0);
      rst = 1'b0;

      // Fastest divide: period 2, one enable per rising edge.
      for (int i = 1; i <= 10; i++) begin
         tick();
         check_val("t1_clk", 32'(clk_out), i % 2);
         check_val("t1_en", 32'(clk_en), i % 2);
      end
      check_val("t1_count", int'(count), 5);

      // Half-period 4, then change to 8 inside a high phase.
      div_sel = 5'd2;
      wait_clk(1'b1, 20);
      check_val("t2_rise_en", 32'(clk_en), 1);
      check_val("t2_rise_count", int'(count), 6);
      tick();
      div_sel = 5'd3;
      run_len(1'b1, n);
      check_val("t2_high_len", n + 1, 4);
      run_len(1'b0, n);
      check_val("t2_low_len", n, 8);
      check_val("t2_count", int'(count), 7);
      run_len(1'b1, n);
      check_val("t2_high8_len", n, 8);

      // Bouncy pause press at the start of a low phase.
      btn_p = 1'b1; tick();
      btn_p = 1'b0; tick();
      btn_p = 1'b1;
      presses = 0;
      for (int i = 3; i <= 16; i++) begin
         tick();
         if (dut.pause_press) presses++;
         if (i == 12) btn_p = 1'b0;
      end
      check_val("t3_mode", 32'(mode), 1);
      check_val("t3_clk", 32'(clk_out), 0);
      check_val("t3_count", int'(count), 8);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dut.pause_press) presses++;
      end
      check_val("t3_presses", presses, 1);
      check_val("t3_mode_hold", 32'(mode), 1);
      check_val("t3_clk_hold", 32'(clk_out), 0);
      check_val("t3_count_hold", int'(count), 8);

      // Single step with half-period 2.
      div_sel = 5'd1;
      btn_s = 1'b1;
      hi = 0; ens = 0; steps = 0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 7) btn_s = 1'b0;
         if (clk_out) hi++;
         if (clk_en) ens++;
         if (mode == 2'b10) steps++;
      end
      check_val("t4_high", hi, 2);
      check_val("t4_en", ens, 1);
      check_val("t4_step_cycles", steps, 2);
      check_val("t4_count", int'(count), 9);
      check_val("t4_mode", 32'(mode), 1);

      // Clamped divider, pause and step pressed together.
      div_sel = 5'd31;
      btn_p = 1'b1; btn_s = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 6) begin
            check_val("t5_pause_pulse", 32'(dut.pause_press), 1);
            check_val("t5_step_pulse", 32'(dut.step_press), 1);
         end
      end
      check_val("t5_mode", 32'(mode), 0);
      check_val("t5_clk", 32'(clk_out), 0);
      btn_p = 1'b0; btn_s = 1'b0;
      run_len(1'b0, n);
      check_val("t5_low_len", n, 16);
      check_val("t5_rise_en", 32'(clk_en), 1);
      check_val("t5_count", int'(count), 10);
      run_len(1'b1, n);
      check_val("t5_high_len", n, 16);

      // Pause at the end of the low phase, then step and reset mid-step.
      btn_p = 1'b1;
      repeat (7) tick();
      btn_p = 1'b0;
      wait_mode(2'b01, 60);
      check_val("t6_count_paused", int'(count), 10);
      btn_s = 1'b1;
      wait_mode(2'b10, 30);
      btn_s = 1'b0;
      check_val("t6_step_en", 32'(clk_en), 1);
      check_val("t6_step_count", int'(count), 11);
      #2 rst = 1'b1;
      #1;
      check_val("t6_rst_clk", 32'(clk_out), 0);
      check_val("t6_rst_en", 32'(clk_en), 0);
      check_val("t6_rst_count", int'(count), 0);
      tick();
      rst = 1'b0;
      tick();
      check_val("t6_mode", 32'(mode), 0);
      check_val("t6_clk", 32'(clk_out), 0);
      check_val("t6_count", int'(count), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
